// File: rtl/score_display.sv
// Two-digit multiplexed 7-segment score display.
// Tear-free snapshot per scan frame, leading-zero blanking, game-over blink.
module score_display #(
   parameter int REFRESH_DIV = 1000,
   parameter int BLINK_DIV   = 5000000
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic [3:0] bcd_ones,
   input  logic [3:0] bcd_tens,
   input  logic       isGameComplete,
   output logic [6:0] seg,
   output logic [1:0] an
);

   localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam logic [RW-1:0] RMAX = RW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);

   localparam logic [0:0] SHOW_ONES = 1'b0;
   localparam logic [0:0] SHOW_TENS = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic [BW-1:0] bcnt_q, bcnt_d, bcnt_cur;
   logic          blink_q, blink_d, blink_cur;
   logic          gc_prev_q;
   logic          rise, blink_eff;
   logic [3:0]    ones_q, ones_d;
   logic [3:0]    tens_q, tens_d;
   logic [6:0]    seg_q, seg_d;
   logic [1:0]    an_q, an_d;

   function automatic logic [6:0] dec7(input logic [3:0] d);
      logic [6:0] r;
      case (d)
         4'd0:    r = 7'h3F;
         4'd1:    r = 7'h06;
         4'd2:    r = 7'h5B;
         4'd3:    r = 7'h4F;
         4'd4:    r = 7'h66;
         4'd5:    r = 7'h6D;
         4'd6:    r = 7'h7D;
         4'd7:    r = 7'h07;
         4'd8:    r = 7'h7F;
         4'd9:    r = 7'h6F;
         default: r = 7'h40;
      endcase
      return r;
   endfunction

   // Scan FSM; snapshot only when a full tens->ones frame boundary passes
   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q + RW'(1);
      ones_d  = ones_q;
      tens_d  = tens_q;
      if (rcnt_q == RMAX) begin
         rcnt_d = '0;
         if (state_q == SHOW_TENS) begin
            state_d = SHOW_ONES;
            ones_d  = bcd_ones;
            tens_d  = bcd_tens;
         end else begin
            state_d = SHOW_TENS;
         end
      end
   end

   always_comb begin
      rise      = isGameComplete & ~gc_prev_q;
      bcnt_cur  = rise ? '0 : bcnt_q;
      blink_cur = rise | blink_q;
      bcnt_d    = '0;
      blink_d   = 1'b1;
      if (isGameComplete) begin
         if (bcnt_cur == BMAX) begin
            bcnt_d  = '0;
            blink_d = ~blink_cur;
         end else begin
            bcnt_d  = bcnt_cur + BW'(1);
            blink_d = blink_cur;
         end
      end
   end

   // A falling edge of isGameComplete unblanks in the same cycle
   always_comb begin
      blink_eff = ~isGameComplete | rise | blink_q;
      an_d      = 2'b00;
      seg_d     = 7'h00;
      if (blink_eff) begin
         if (state_q == SHOW_ONES) begin
            an_d  = 2'b01;
            seg_d = dec7(ones_q);
         end else if (tens_q != 4'd0) begin
            an_d  = 2'b10;
            seg_d = dec7(tens_q);
         end
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q   <= SHOW_ONES;
         rcnt_q    <= '0;
         bcnt_q    <= '0;
         blink_q   <= 1'b1;
         gc_prev_q <= 1'b0;
         ones_q    <= 4'd0;
         tens_q    <= 4'd0;
         seg_q     <= 7'h00;
         an_q      <= 2'b00;
      end else begin
         state_q   <= state_d;
         rcnt_q    <= rcnt_d;
         bcnt_q    <= bcnt_d;
         blink_q   <= blink_d;
         gc_prev_q <= isGameComplete;
         ones_q    <= ones_d;
         tens_q    <= tens_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
      end
   end

   assign seg = seg_q;
   assign an  = an_q;

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display (REFRESH_DIV=4, BLINK_DIV=16).
// Driver queues the expected output per cycle; monitor pops after each edge.
module tb_score_display;

   logic       clk;
   logic       nRst;
   logic [3:0] bcd_ones;
   logic [3:0] bcd_tens;
   logic       isGameComplete;
   logic [6:0] seg;
   logic [1:0] an;

   typedef struct {
      int         cyc;
      logic [1:0] an;
      logic [6:0] seg;
   } exp_t;

   exp_t q[$];
   int   t;
   int   n_chk;
   int   n_pass;

   score_display #(
      .REFRESH_DIV(4),
      .BLINK_DIV(16)
   ) dut (
      .clk(clk),
      .nRst(nRst),
      .bcd_ones(bcd_ones),
      .bcd_tens(bcd_tens),
      .isGameComplete(isGameComplete),
      .seg(seg),
      .an(an)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         n_chk++;
         if (an === e.an && seg === e.seg) n_pass++;
         else $display("FAIL scan cyc=%0d got an=%b seg=%h expected an=%b seg=%h",
                       e.cyc, an, seg, e.an, e.seg);
      end
   end

   task automatic chk(input string nm, input logic [1:0] a, input logic [6:0] s);
      n_chk++;
      if (an === a && seg === s) n_pass++;
      else $display("FAIL %s got an=%b seg=%h expected an=%b seg=%h",
                    nm, an, seg, a, s);
   endtask

   // Cycle t is in the ones slot when (t/4) is even
   task automatic go(input int n,
                     input logic [1:0] a1, input logic [6:0] s1,
                     input logic [1:0] a2, input logic [6:0] s2);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         e.cyc = t;
         if (((t / 4) % 2) == 0) begin
            e.an  = a1;
            e.seg = s1;
         end else begin
            e.an  = a2;
            e.seg = s2;
         end
         q.push_back(e);
         t++;
      end
   endtask

   task automatic set_in(input logic gc, input logic [3:0] o, input logic [3:0] tn);
      @(posedge clk);
      #2;
      isGameComplete = gc;
      bcd_ones       = o;
      bcd_tens       = tn;
   endtask

   task automatic release_rst();
      @(posedge clk);
      #2;
      nRst = 1'b1;
      t    = 0;
   endtask

   initial begin
      n_chk          = 0;
      n_pass         = 0;
      t              = 0;
      nRst           = 1'b0;
      bcd_ones       = 4'd0;
      bcd_tens       = 4'd0;
      isGameComplete = 1'b0;
      #1;
      chk("reset_async", 2'b00, 7'h00);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_hold", 2'b00, 7'h00);

      release_rst();
      go(17, 2'b01, 7'h3F, 2'b00, 7'h00);
      set_in(1'b0, 4'd2, 4'd4);
      go(7, 2'b01, 7'h3F, 2'b00, 7'h00);
      go(10, 2'b01, 7'h5B, 2'b10, 7'h66);
      set_in(1'b0, 4'd11, 4'd0);
      go(6, 2'b01, 7'h5B, 2'b10, 7'h66);
      go(16, 2'b01, 7'h40, 2'b00, 7'h00);

      set_in(1'b0, 4'd7, 4'd3);
      go(8, 2'b01, 7'h40, 2'b00, 7'h00);
      go(4, 2'b01, 7'h07, 2'b10, 7'h4F);
      set_in(1'b1, 4'd7, 4'd3);
      go(16, 2'b01, 7'h07, 2'b10, 7'h4F);
      go(16, 2'b00, 7'h00, 2'b00, 7'h00);
      go(16, 2'b01, 7'h07, 2'b10, 7'h4F);
      go(5, 2'b00, 7'h00, 2'b00, 7'h00);
      set_in(1'b0, 4'd7, 4'd3);
      go(16, 2'b01, 7'h07, 2'b10, 7'h4F);

      set_in(1'b1, 4'd7, 4'd3);
      go(16, 2'b01, 7'h07, 2'b10, 7'h4F);
      go(4, 2'b00, 7'h00, 2'b00, 7'h00);
      @(posedge clk);
      #2;
      nRst = 1'b0;
      #1;
      chk("reset_blink_off", 2'b00, 7'h00);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_held_gc", 2'b00, 7'h00);

      release_rst();
      go(8, 2'b01, 7'h3F, 2'b00, 7'h00);
      go(8, 2'b01, 7'h07, 2'b10, 7'h4F);
      go(6, 2'b00, 7'h00, 2'b00, 7'h00);
      set_in(1'b0, 4'd7, 4'd3);
      go(7, 2'b01, 7'h07, 2'b10, 7'h4F);
      @(posedge clk);
      #1;
      chk("pre_reset_tens", 2'b10, 7'h4F);
      #1;
      nRst = 1'b0;
      #1;
      chk("reset_tens", 2'b00, 7'h00);
      bcd_ones = 4'd0;
      bcd_tens = 4'd0;
      repeat (2) @(posedge clk);

      release_rst();
      go(8, 2'b01, 7'h3F, 2'b00, 7'h00);

      @(posedge clk);
      #3;
      n_chk++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL drain left=%0d expected 0", q.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
